// File: rtl/regfile_port_ctrl_if.sv
// rtl/regfile_port_ctrl_if.sv - core and debug write-request channels into the register-file port controller
interface regfile_port_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          core_wvalid;
    logic          core_wready;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;
    logic          dbg_wvalid;
    logic          dbg_wready;
    logic [AW-1:0] dbg_waddr;
    logic [DW-1:0] dbg_wdata;

    modport master (
        output core_wvalid, core_waddr, core_wdata,
        output dbg_wvalid, dbg_waddr, dbg_wdata,
        input  core_wready, dbg_wready
    );

    modport slave (
        input  core_wvalid, core_waddr, core_wdata,
        input  dbg_wvalid, dbg_waddr, dbg_wdata,
        output core_wready, dbg_wready
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// rtl/regfile_port_ctrl.sv - register-file port controller: read decode, round-robin write arbitration, clear sweep
// Optional same-cycle write-through on the read ports: REGCTL_BYPASS_EN
module regfile_port_ctrl #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    regfile_port_ctrl_if.slave wr,
    input  logic             clr_req,
    output logic             busy,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [NREGS-1:0] wen,
    output logic [DW-1:0]    wdata,
    output logic [NREGS-1:0] ren1,
    output logic [NREGS-1:0] ren2,
    input  logic [DW-1:0]    bl1,
    input  logic [DW-1:0]    bl2,
    output logic [DW-1:0]    rdata1,
    output logic [DW-1:0]    rdata2
);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]       NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0]     LAST    = AW'(NREGS - 1);
    localparam logic [NREGS-1:0]  ROW0    = {{(NREGS-1){1'b0}}, 1'b1};
    localparam logic              RR_CORE = 1'b0;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rr_q, rr_d;

    logic             grant_core, grant_dbg;
    logic [AW-1:0]    waddr_c;
    logic [DW-1:0]    wdata_c;
    logic [NREGS-1:0] wen_c;
    logic [NREGS-1:0] ren1_c, ren2_c;
    logic [DW-1:0]    rdata1_c, rdata2_c;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] a);
        return in_range(a) ? (ROW0 << a) : '0;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            rr_q    <= RR_CORE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // Arbitration, sweep sequencing and write-port drive.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        grant_core = 1'b0;
        grant_dbg  = 1'b0;
        waddr_c    = '0;
        wdata_c    = '0;
        wen_c      = '0;
        case (state_q)
            RUN: begin
                grant_core = wr.core_wvalid && (!wr.dbg_wvalid || rr_q == RR_CORE);
                grant_dbg  = wr.dbg_wvalid && (!wr.core_wvalid || rr_q != RR_CORE);
                // The pointer only moves when both sides actually competed.
                if (wr.core_wvalid && wr.dbg_wvalid) begin
                    rr_d = ~rr_q;
                end
                if (grant_core) begin
                    waddr_c = wr.core_waddr;
                    wdata_c = wr.core_wdata;
                    wen_c   = onehot(wr.core_waddr);
                end else if (grant_dbg) begin
                    waddr_c = wr.dbg_waddr;
                    wdata_c = wr.dbg_wdata;
                    wen_c   = onehot(wr.dbg_waddr);
                end
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                wen_c = onehot(cnt_q);
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Read decode; out-of-range addresses select no row and return zero.
    always_comb begin
        ren1_c   = onehot(rd_addr1);
        ren2_c   = onehot(rd_addr2);
        rdata1_c = in_range(rd_addr1) ? bl1 : '0;
        rdata2_c = in_range(rd_addr2) ? bl2 : '0;
`ifdef REGCTL_BYPASS_EN
        if (state_q == RUN && (grant_core || grant_dbg) && in_range(waddr_c)) begin
            if (rd_addr1 == waddr_c) rdata1_c = wdata_c;
            if (rd_addr2 == waddr_c) rdata2_c = wdata_c;
        end
        if (state_q == CLEAR) begin
            if (rd_addr1 == cnt_q) rdata1_c = '0;
            if (rd_addr2 == cnt_q) rdata2_c = '0;
        end
`endif
    end

    // Everything toward the array and requesters is held quiet while reset is asserted.
    always_comb begin
        wr.core_wready = rst & grant_core;
        wr.dbg_wready  = rst & grant_dbg;
        busy           = rst & (state_q == CLEAR);
        wen            = rst ? wen_c : '0;
        wdata          = rst ? wdata_c : '0;
        ren1           = rst ? ren1_c : '0;
        ren2           = rst ? ren2_c : '0;
        rdata1         = rst ? rdata1_c : '0;
        rdata2         = rst ? rdata2_c : '0;
    end

endmodule
